tdc_phase_encoder: RTL and testbench

Generates 32-bit circular-thermometer delay-line codes from 5-bit phase values. The TDC phase decoder resolves these codes back to phase. It sits in the TDC_2.0 self-test path and drives the decoder input mux during calibration and BIST. It emits either one held code or a 32-step phase sweep. An optional single-bit bubble can be injected to exercise decoder robustness.

---
 rtl/tdc_phase_encoder.sv | 147 ++++++++++++++
 tb/tb_tdc_phase_encoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_phase_encoder.sv
// Circular-thermometer code generator for exercising the TDC phase decoder: one held code or a 32-step sweep.
// Optional single-bit bubble injection is enabled by defining TDC_BUBBLE_INJECT_EN.
module tdc_phase_encoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [4:0]  phase_in,
    input  logic        abort,
`ifdef TDC_BUBBLE_INJECT_EN
    input  logic        bubble_en,
    input  logic [4:0]  bubble_sel,
`endif
    output logic        ready,
    output logic        busy,
    output logic [31:0] code_out,
    output logic        code_valid,
    output logic [4:0]  phase_out,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [4:0]  phase_q, phase_d;
    logic [31:0] code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  step_q, step_d;
    logic [4:0]  phase_inc;
    logic [31:0] start_mask, run_mask;

    // 16 contiguous ones rotated into place; the upper phase half is the complement ring.
    function automatic logic [31:0] encode(input logic [4:0] p);
        logic [4:0]  amt;
        logic [31:0] base;
        logic [31:0] rot;
        amt  = 5'd16 - {1'b0, p[3:0]};
        base = 32'h0000_FFFF;
        rot  = (base << amt) | (base >> (6'd32 - {1'b0, amt}));
        return rot ^ {32{~p[4]}};
    endfunction

`ifdef TDC_BUBBLE_INJECT_EN
    logic       bub_en_q, bub_en_d;
    logic [4:0] bub_sel_q, bub_sel_d;
    assign start_mask = bubble_en ? (32'd1 << bubble_sel) : 32'd0;
    assign run_mask   = bub_en_q ? (32'd1 << bub_sel_q) : 32'd0;
`else
    assign start_mask = 32'd0;
    assign run_mask   = 32'd0;
`endif

    assign phase_inc = phase_q + 5'd1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        phase_d = phase_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
`ifdef TDC_BUBBLE_INJECT_EN
        bub_en_d  = bub_en_q;
        bub_sel_d = bub_sel_q;
`endif
        if (abort) begin
            // code_out and phase_out are deliberately left at their last values
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_HOLD;
                        mode_d  = mode;
                        phase_d = phase_in;
                        code_d  = encode(phase_in) ^ start_mask;
                        cnt_d   = HOLD_RELOAD;
                        step_d  = 6'd1;
`ifdef TDC_BUBBLE_INJECT_EN
                        bub_en_d  = bubble_en;
                        bub_sel_d = bubble_sel;
`endif
                    end
                end
                S_HOLD: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else if (mode_q && (step_q != 6'd32)) begin
                        phase_d = phase_inc;
                        code_d  = encode(phase_inc) ^ run_mask;
                        cnt_d   = HOLD_RELOAD;
                        step_d  = step_q + 6'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            phase_q <= 5'd0;
            code_q  <= 32'h0000_FFFF;
            cnt_q   <= 8'd0;
            step_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

`ifdef TDC_BUBBLE_INJECT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bub_en_q  <= 1'b0;
            bub_sel_q <= 5'd0;
        end else begin
            bub_en_q  <= bub_en_d;
            bub_sel_q <= bub_sel_d;
        end
    end
`endif

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q == S_HOLD);
    assign code_valid = (state_q == S_HOLD);
    assign done       = (state_q == S_DONE);
    assign code_out   = code_q;
    assign phase_out  = phase_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tdc_phase_encoder.sv
// Bench for tdc_phase_encoder: one instance at HOLD_CYCLES=4 and one at HOLD_CYCLES=1.
// Every valid cycle of either instance is checked against an expected queue built from a thermometer model.
module tb_tdc_phase_encoder;

    localparam int HC4 = 4;
    localparam int HC1 = 1;

    logic        clk;
    logic        rst_n;
    logic        start4, start1;
    logic        mode;
    logic [4:0]  phase_in;
    logic        abort;
    logic        bubble_en;
    logic [4:0]  bubble_sel;

    logic        ready4, busy4, valid4, done4;
    logic [31:0] code4;
    logic [4:0]  phase4;
    logic [1:0]  st4;
    logic        ready1, busy1, valid1, done1;
    logic [31:0] code1;
    logic [4:0]  phase1;
    logic [1:0]  st1;

    tdc_phase_encoder #(.HOLD_CYCLES(HC4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode), .phase_in(phase_in), .abort(abort),
`ifdef TDC_BUBBLE_INJECT_EN
        .bubble_en(bubble_en), .bubble_sel(bubble_sel),
`endif
        .ready(ready4), .busy(busy4), .code_out(code4), .code_valid(valid4),
        .phase_out(phase4), .done(done4), .dbg_state(st4)
    );

    tdc_phase_encoder #(.HOLD_CYCLES(HC1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .phase_in(phase_in), .abort(abort),
`ifdef TDC_BUBBLE_INJECT_EN
        .bubble_en(bubble_en), .bubble_sel(bubble_sel),
`endif
        .ready(ready1), .busy(busy1), .code_out(code1), .code_valid(valid1),
        .phase_out(phase1), .done(done1), .dbg_state(st1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done4_cnt = 0;
    int done1_cnt = 0;
    logic [36:0] exp4_q[$];
    logic [36:0] exp1_q[$];

    typedef struct {
        logic [4:0]  phase;
        logic [31:0] code;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bit i is set when (i + P) mod 32 lands in the lower half of the ring
    function automatic logic [31:0] model_code(input int p);
        logic [31:0] c;
        for (int i = 0; i < 32; i++) c[i] = (((i + p) % 32) < 16);
        return c;
    endfunction

    task automatic push_exp(input int which, input logic m, input int p, input logic [31:0] mask);
        int hc;
        int steps;
        int ph;
        hc    = (which == 4) ? HC4 : HC1;
        steps = m ? 32 : 1;
        for (int s = 0; s < steps; s++) begin
            ph = (p + s) % 32;
            for (int c = 0; c < hc; c++) begin
                if (which == 4) exp4_q.push_back({5'(ph), model_code(ph) ^ mask});
                else            exp1_q.push_back({5'(ph), model_code(ph) ^ mask});
            end
        end
    endtask

    // scoreboard: one expected entry per valid cycle
    always @(negedge clk) begin
        if (done4) done4_cnt++;
        if (done1) done1_cnt++;
        if (valid4) begin
            if (exp4_q.size() == 0) check("sb4_underflow", 64'(valid4), 64'd0);
            else check("sb4_code", {27'd0, phase4, code4}, {27'd0, exp4_q.pop_front()});
        end
        if (valid1) begin
            if (exp1_q.size() == 0) check("sb1_underflow", 64'(valid1), 64'd0);
            else check("sb1_code", {27'd0, phase1, code1}, {27'd0, exp1_q.pop_front()});
        end
    end

    // driver: present a request for one cycle; returns just after the accepting edge
    task automatic drive_start(input int which, input logic m, input logic [4:0] p,
                               input logic ben, input logic [4:0] bsel);
        @(posedge clk); #1;
        mode = m; phase_in = p; bubble_en = ben; bubble_sel = bsel;
        if (which == 4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; start1 = 1'b0;
    endtask

    task automatic run_single4(input logic [4:0] p, input logic [31:0] exp_code, input string tag);
        int d0;
        push_exp(4, 1'b0, int'(p), 32'd0);
        drive_start(4, 1'b0, p, 1'b0, 5'd0);
        d0 = done4_cnt;
        check({tag, "_code"}, 64'(code4), 64'(exp_code));
        check({tag, "_busy"}, {62'd0, busy4, ready4}, 64'd2);
        repeat (HC4) @(posedge clk);
        #1;
        check({tag, "_done"}, {62'd0, done4, valid4}, 64'd2);
        @(posedge clk); #1;
        check({tag, "_ready"}, {62'd0, ready4, done4}, 64'd2);
        check({tag, "_done_cnt"}, 64'(done4_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        logic [31:0] held;
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; mode = 1'b0; phase_in = 5'd0;
        abort = 1'b0; bubble_en = 1'b0; bubble_sel = 5'd0;

        vecs[0] = '{5'd0,  32'h0000_FFFF};
        vecs[1] = '{5'd5,  32'hF800_07FF};
        vecs[2] = '{5'd15, 32'hFFFE_0001};
        vecs[3] = '{5'd16, 32'hFFFF_0000};
        vecs[4] = '{5'd21, 32'h07FF_F800};
        vecs[5] = '{5'd31, 32'h0001_FFFE};
        vecs[6] = '{5'd1,  32'h8000_7FFF};
        vecs[7] = '{5'd17, 32'h7FFF_8000};

        #12;
        check("rst_code", 64'(code4), 64'h0000_FFFF);
        check("rst_phase", 64'(phase4), 64'd0);
        check("rst_flags", {60'd0, ready4, busy4, valid4, done4}, 64'h8);
        check("rst_code1", 64'(code1), 64'h0000_FFFF);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("idle_flags", {60'd0, ready4, busy4, valid4, done4}, 64'h8);

        // single codes from the table
        for (int i = 0; i < 8; i++)
            run_single4(vecs[i].phase, vecs[i].code, $sformatf("single_p%0d", vecs[i].phase));

        // HOLD_CYCLES=1 sweep from 30 wrapping through 0
        push_exp(1, 1'b1, 30, 32'd0);
        d0 = done1_cnt;
        drive_start(1, 1'b1, 5'd30, 1'b0, 5'd0);
        check("sw1_first", {59'd0, phase1}, 64'd30);
        repeat (32) @(posedge clk);
        #1 check("sw1_done", {62'd0, done1, valid1}, 64'd2);
        check("sw1_last_phase", {59'd0, phase1}, 64'd29);
        @(posedge clk); #1 check("sw1_ready", 64'(ready1), 64'd1);
        check("sw1_done_cnt", 64'(done1_cnt - d0), 64'd1);

        // abort on the 3rd HOLD cycle
        push_exp(4, 1'b0, 9, 32'd0);
        d0 = done4_cnt;
        drive_start(4, 1'b0, 5'd9, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        held = code4;
        @(posedge clk); #1 abort = 1'b0;
        exp4_q.delete();
        check("abort_flags", {60'd0, ready4, busy4, valid4, done4}, 64'h8);
        check("abort_code", 64'(code4), 64'(model_code(9)));
        check("abort_code_held", 64'(code4), 64'(held));
        repeat (3) @(posedge clk);
        #1 check("abort_no_done", 64'(done4_cnt - d0), 64'd0);

        // start while busy is ignored; the HOLD_CYCLES=4 sweep finishes all 32 steps
        push_exp(4, 1'b1, 3, 32'd0);
        d0 = done4_cnt;
        drive_start(4, 1'b1, 5'd3, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(5, 30)) @(posedge clk);
            #1 start4 = 1'b1; mode = 1'b0; phase_in = 5'($urandom_range(0, 31));
            @(posedge clk); #1 start4 = 1'b0;
        end
        wait (done4 == 1'b1 || done4_cnt != d0);
        @(posedge clk); #1;
        check("sw4_done_cnt", 64'(done4_cnt - d0), 64'd1);
        check("sw4_ready", 64'(ready4), 64'd1);
        check("sw4_queue_empty", 64'(exp4_q.size()), 64'd0);
        run_single4(5'd16, 32'hFFFF_0000, "after_busy_p16");

        // abort and start together in IDLE: abort wins
        @(posedge clk); #1 start4 = 1'b1; abort = 1'b1; phase_in = 5'd7;
        @(posedge clk); #1 start4 = 1'b0; abort = 1'b0;
        check("abort_start_idle", {60'd0, ready4, busy4, valid4, done4}, 64'h8);
        check("abort_start_code", 64'(code4), 64'hFFFF_0000);

        // asynchronous reset mid-sweep
        push_exp(4, 1'b1, 12, 32'd0);
        drive_start(4, 1'b1, 5'd12, 1'b0, 5'd0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flags", {60'd0, ready4, busy4, valid4, done4}, 64'h8);
        check("arst_code", 64'(code4), 64'h0000_FFFF);
        check("arst_phase", 64'(phase4), 64'd0);
        #1 rst_n = 1'b1;
        exp4_q.delete();
        repeat (5) @(posedge clk);
        #1 check("arst_stays_idle", {62'd0, ready4, valid4}, 64'd2);

`ifdef TDC_BUBBLE_INJECT_EN
        push_exp(4, 1'b0, 0, 32'h0000_0008);
        drive_start(4, 1'b0, 5'd0, 1'b1, 5'd3);
        check("bubble_code", 64'(code4), 64'h0000_FFF7);
        check("bubble_phase", 64'(phase4), 64'd0);
        repeat (HC4 + 1) @(posedge clk);
        #1 bubble_en = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("final_q4_empty", 64'(exp4_q.size()), 64'd0);
        check("final_q1_empty", 64'(exp1_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global time bound so a stuck DUT still ends in a summary
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
